// File: rtl/mdu_ex_if.sv
// mdu_ex_if: EX-stage multiply/divide request and HI/LO result bundle.
// The master (EX stage / hazard logic) issues start, op and operands;
// the slave (mdu_ex) returns busy, done and the architectural HI/LO.
interface mdu_ex_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, hi, lo
  );
endinterface : mdu_ex_if

// File: rtl/mdu_ex.sv
// mdu_ex: multiply/divide unit beside the ALU, owner of the HI/LO pair.
// mult/multu/div/divu run for a fixed number of cycles (MULT_CYCLES /
// DIV_CYCLES) with busy high throughout; mthi/mtlo write in a single edge.
// Optional feature macro: MDU_MADD_EN enables madd/msub (ops 6/7); when it
// is undefined those ops are no-ops and the accumulate datapath is absent.
module mdu_ex #(
  parameter int unsigned MULT_CYCLES = 5,  // legal range 1-15
  parameter int unsigned DIV_CYCLES  = 10  // legal range 1-15
) (
  input  logic    clk,
  input  logic    reset,   // asynchronous, active-low
  mdu_ex_if.slave md
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  op_e         op_q,    op_d;
  logic [31:0] rs_q,    rs_d;
  logic [31:0] rt_q,    rt_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic        done_q,  done_d;

  op_e         req_op;
  logic        req_is_mult;
  logic        req_is_div;

  logic [63:0] mul_a, mul_b, prod;
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic [63:0] commit_val;

  // Classify the incoming request: which ops start a multi-cycle run.
  always_comb begin
    req_op      = op_e'(md.op);
    req_is_div  = (req_op == OP_DIV) || (req_op == OP_DIVU);
`ifdef MDU_MADD_EN
    req_is_mult = (req_op == OP_MULT) || (req_op == OP_MULTU) ||
                  (req_op == OP_MADD) || (req_op == OP_MSUB);
`else
    req_is_mult = (req_op == OP_MULT) || (req_op == OP_MULTU);
`endif
  end

  // Arithmetic on the latched operands. Operands are frozen for the whole
  // run, so this logic only has to settle within N cycles (multicycle path).
  always_comb begin
    // Multiply: extend both operands to 64 bits; the low 64 bits of the
    // product are then correct for both signed and unsigned forms.
    if (op_q == OP_MULTU) begin
      mul_a = {32'b0, rs_q};
      mul_b = {32'b0, rt_q};
    end else begin
      mul_a = {{32{rs_q[31]}}, rs_q};
      mul_b = {{32{rt_q[31]}}, rt_q};
    end
    prod = mul_a * mul_b;

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero and the remainder follows the dividend. 0x80000000 / -1 falls
    // out as 0x80000000 rem 0 without a special case.
    div_signed = (op_q == OP_DIV);
    a_neg      = div_signed && rs_q[31];
    b_neg      = div_signed && rt_q[31];
    a_mag      = a_neg ? (32'd0 - rs_q) : rs_q;
    b_mag      = b_neg ? (32'd0 - rt_q) : rt_q;
    if (b_mag == 32'd0) begin
      q_mag = 32'd0;
      r_mag = 32'd0;
    end else begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem  = a_neg ? (32'd0 - r_mag) : r_mag;

    // Value written to {hi,lo} at the commit edge; a divide by zero keeps
    // the old pair.
    commit_val = {hi_q, lo_q};
    case (op_q)
      OP_MULT, OP_MULTU: commit_val = prod;
      OP_DIV, OP_DIVU: begin
        if (rt_q != 32'd0) commit_val = {rem, quot};
      end
`ifdef MDU_MADD_EN
      OP_MADD: commit_val = {hi_q, lo_q} + prod;
      OP_MSUB: commit_val = {hi_q, lo_q} - prod;
`endif
      default: commit_val = {hi_q, lo_q};
    endcase
  end

  // Next-state and register updates for the IDLE/RUN controller.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (md.start) begin
          if (req_is_mult || req_is_div) begin
            state_d = RUN;
            cnt_d   = req_is_div ? DIV_CNT : MULT_CNT;
            op_d    = req_op;
            rs_d    = md.rs_val;
            rt_d    = md.rt_val;
          end else if (req_op == OP_MTHI) begin
            hi_d = md.rs_val;
          end else if (req_op == OP_MTLO) begin
            lo_d = md.rs_val;
          end
        end
      end
      RUN: begin
        // start is ignored here; the hazard unit never issues one.
        if (cnt_q <= 4'd1) begin
          state_d      = IDLE;
          cnt_d        = 4'd0;
          done_d       = 1'b1;
          {hi_d, lo_d} = commit_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset clears everything, aborting any run in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= OP_MULT;
      rs_q    <= 32'd0;
      rt_q    <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign md.busy = (state_q == RUN);
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

  // done only ever follows a commit, by which point the unit is idle.
  a_done_not_busy: assert property (@(posedge clk) disable iff (!reset)
    done_q |-> (state_q == IDLE));

endmodule : mdu_ex

// File: doc/mdu_ex.md
# mdu_ex

Multiply/divide unit for the pipelined MIPS core. It sits beside the ALU in the EX stage and owns the HI/LO register pair. It runs `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` with a fixed multi-cycle latency. It raises `busy` so the hazard logic stalls any later MD-class instruction (`mfhi`, `mflo` or a new start) until the result is committed.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/msub; legal range 1-15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1-15

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  EX stage issues an MD instruction this cycle
- op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 msub
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- busy  out  1  operation in flight; hazard unit stalls MD instructions while high
- done  out  1  one-cycle pulse in the cycle after HI/LO commit a multi-cycle result
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE and RUN.
- A 4-bit down-counter runs in RUN.
- Operands and op are latched at the accepting edge. Later changes on rs_val/rt_val have no effect.
- IDLE, start=1, op 0-3 or 6-7:
  - latch operands;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE, start=1, op 4: hi<=rs_val at that edge; stay IDLE; no busy, no done.
- IDLE, start=1, op 5: lo<=rs_val at that edge; stay IDLE; no busy, no done.
- RUN: decrement counter each edge. At the edge where the counter is 1:
  - write the result to {hi,lo};
  - return to IDLE;
  - set done for the next cycle.
- start=1 while busy: ignored. The hazard unit guarantees this never happens; the bench still checks that state is unchanged.
- Arithmetic:
  - mult/multu: signed/unsigned 32x32 -> 64. hi=upper 32 bits, lo=lower 32 bits.
  - div/divu: lo=quotient, hi=remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Divide by zero: hi and lo are left unchanged. busy/done timing is identical to a normal divide.
  - 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0.
  - madd/msub (signed): {hi,lo} <= {hi,lo} ± rs*rt. The accumulator value is the one present at commit time, with 64-bit wrap-around.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0.
- Reset asserted mid-RUN aborts the operation: no commit, no done.
- The edge that accepts start is E0. busy is high from just after E0 through the cycle ending at edge E_N, so busy is high for exactly N cycles.
  - N = MULT_CYCLES or DIV_CYCLES.
  - hi/lo change at E_N.
  - busy falls after E_N.
  - done is high for the one cycle following E_N.
- A new start is accepted at E_N+1 at the earliest, i.e. back-to-back operations with no bubble beyond busy.
- mthi/mtlo take effect at the accepting edge; the new value is visible in the following cycle.
- hi/lo keep their old values throughout RUN. No partial results are ever visible.

## Configuration
- MDU_MADD_EN defined: op 6 (madd) and op 7 (msub) are implemented as above.
- MDU_MADD_EN undefined: ops 6 and 7 are treated as no-ops.
  - no busy, no done, hi/lo unchanged;
  - the accumulate datapath is not synthesised.

## Test plan
- mult: reset low 20 ns then high; start, op=0, rs=0xFFFFFFFE(-2), rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done high 1 cycle.
- multu then divu back-to-back:
  - multu 0xFFFFFFFF x 2 -> hi=1, lo=0xFFFFFFFE.
  - divu 7/2 started the cycle busy falls -> accepted; 10 busy cycles; lo=3, hi=1.
- Signed divide:
  - div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div 5/0 with prior hi=0x11, lo=0x22 -> unchanged after 10 cycles; done still pulses.
- mthi/mtlo and ignored start:
  - mthi 0x1234 -> hi=0x1234 next cycle; busy stays 0.
  - start mult pulsed during another mult's RUN -> ignored; only the first result commits.
- Reset mid-RUN: assert reset at cycle 3 of a div -> busy, done, hi, lo = 0 immediately; no commit after release.
- With MDU_MADD_EN, hi=0, lo=10, madd 3x4 -> lo=22, hi=0 after 5 cycles. Without MDU_MADD_EN -> values unchanged, busy never rises.
